// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 core's memory arbitration logic:
// default widths, the arbiter FSM state and the requester identity.
package mips32_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] max);
    logic [3:0] res;
    if (val >= max) begin
      res = max;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mips32_arb_prio.sv
// Two-way priority pick: the high side normally wins, but a low side that has
// lost CNT_MAX consecutive eligible cycles is promoted for one grant.
module mips32_arb_prio
  import mips32_pkg::*;
#(
  parameter int CNT_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic elig,
  input  logic hi_req,
  input  logic lo_req,
  input  logic lo_block,
  output logic hi_gnt,
  output logic lo_gnt
);

  localparam logic [3:0] MAX_C = 4'(CNT_MAX);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       lo_eff;
  logic       lo_prio;

  // Grant decode and starvation counter next-state
  always_comb begin
    lo_eff  = lo_req & ~lo_block;
    lo_prio = (cnt_q == MAX_C);
    lo_gnt  = elig & lo_eff & (~hi_req | lo_prio);
    hi_gnt  = elig & hi_req & ~(lo_eff & lo_prio);
    cnt_d   = cnt_q;
    if (!lo_eff) begin
      cnt_d = 4'd0;
    end else if (lo_gnt) begin
      cnt_d = 4'd0;
    end else if (hi_gnt) begin
      cnt_d = sat_inc4(cnt_q, MAX_C);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares the core's single-port unified memory between instruction fetch and
// the data stage, one transaction at a time (issue, latency wait, response).
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          dm_req_valid,
  output logic          dm_req_ready,
  input  logic          dm_req_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_rsp_valid,
  output logic [DW-1:0] dm_rsp_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

  arb_state_e    state_q, state_d;
  req_id_e       owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          elig_s;
  logic          if_gnt_s;
  logic          dm_gnt_s;

  // Gating with rst_n keeps the readies low while reset is asserted
  assign elig_s = rst_n & ((state_q == IDLE) | (state_q == RESP));

  mips32_arb_prio #(
    .CNT_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk1),
    .rst_n    (rst_n),
    .elig     (elig_s),
    .hi_req   (dm_req_valid),
    .lo_req   (if_req_valid),
    .lo_block (halted),
    .hi_gnt   (dm_gnt_s),
    .lo_gnt   (if_gnt_s)
  );

  // FSM next-state, request capture and read-data capture
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wcnt_d     = wcnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (if_gnt_s || dm_gnt_s) begin
          state_d = ISSUE;
          owner_d = if_gnt_s ? REQ_IF : REQ_DM;
          addr_d  = if_gnt_s ? if_addr : dm_addr;
          we_d    = dm_gnt_s & dm_req_we;
          wdata_d = dm_gnt_s ? dm_wdata : {DW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = WAIT_INIT;
      end
      WAIT: begin
        if (wcnt_q == 3'd0) begin
          state_d = RESP;
          if (owner_q == REQ_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = we_q ? {DW{1'b0}} : mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= REQ_IF;
      we_q       <= 1'b0;
      addr_q     <= {AW{1'b0}};
      wdata_q    <= {DW{1'b0}};
      wcnt_q     <= 3'd0;
      if_rdata_q <= {DW{1'b0}};
      dm_rdata_q <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wcnt_q     <= wcnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_req_ready = if_gnt_s;
  assign dm_req_ready = dm_gnt_s;
  assign if_rsp_valid = (state_q == RESP) && (owner_q == REQ_IF);
  assign dm_rsp_valid = (state_q == RESP) && (owner_q == REQ_DM);
  assign if_rsp_data  = if_rdata_q;
  assign dm_rsp_data  = dm_rdata_q;
  assign mem_en       = (state_q == ISSUE);
  assign mem_we       = (state_q == ISSUE) && we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Table-driven bench for mips32_mem_arbiter with a response scoreboard; a
// second instance with MEM_LAT = 4 covers reset in the middle of a transaction.
module tb_mips32_mem_arbiter;

  logic        clk1 = 1'b0;
  logic        rst_n, rst4_n;
  logic        halted;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [9:0]  if_addr;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rsp_data;
  logic        mem_en, mem_we, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        if4_v, if4_rdy, if4_rsp_v, d4_rdy, d4_rsp_v, m4_en, m4_we, busy4;
  logic [9:0]  if4_addr, m4_addr;
  logic [31:0] if4_rsp_d, d4_rsp_d, m4_wd, m4_rd;
  logic [31:0] pipe4 [4];

  always #5 clk1 = ~clk1;

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(4), .STARVE_MAX(3)) u_dut4 (
    .clk1(clk1), .rst_n(rst4_n), .halted(1'b0),
    .if_req_valid(if4_v), .if_req_ready(if4_rdy), .if_addr(if4_addr),
    .if_rsp_valid(if4_rsp_v), .if_rsp_data(if4_rsp_d),
    .dm_req_valid(1'b0), .dm_req_ready(d4_rdy), .dm_req_we(1'b0),
    .dm_addr(10'd0), .dm_wdata(32'd0), .dm_rsp_valid(d4_rsp_v), .dm_rsp_data(d4_rsp_d),
    .mem_en(m4_en), .mem_we(m4_we), .mem_addr(m4_addr), .mem_wdata(m4_wd),
    .mem_rdata(m4_rd), .busy(busy4));

  function automatic logic [31:0] init_val(input int a);
    return (a == 0) ? 32'h2801000a : (32'h1000_0000 | 32'(a));
  endfunction

  // Memory model, latency 1: read data appears in the cycle after mem_en
  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  always @(posedge clk1) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      rd_q <= 32'd0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_q <= mem[mem_addr];
    end
  end
  assign mem_rdata = rd_q;

  // Memory model, latency 4: data is a fixed pattern of the address
  always @(posedge clk1) begin
    pipe4[0] <= m4_en ? (32'hA5A5_0000 | {22'd0, m4_addr}) : 32'd0;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign m4_rd = pipe4[3];

  typedef struct {
    logic hlt, ifv; logic [9:0] ifa;
    logic dmv, dmwe; logic [9:0] dma; logic [31:0] dmwd;
    logic e_ifr, e_dmr, e_en, e_we, e_busy; logic [9:0] e_addr;
  } vec_t;

  typedef struct { bit is_if; logic [31:0] data; int due; } exp_t;

  vec_t        tbl[$];
  exp_t        sbq[$];
  logic [31:0] ref_mem [1024];
  int          cyc, n_tests, n_fail;

  function automatic vec_t v(logic hlt, logic ifv, logic [9:0] ifa, logic dmv, logic dmwe,
                             logic [9:0] dma, logic [31:0] dmwd, logic e_ifr, logic e_dmr,
                             logic e_en, logic e_we, logic e_busy, logic [9:0] e_addr);
    vec_t r;
    r.hlt = hlt; r.ifv = ifv; r.ifa = ifa; r.dmv = dmv; r.dmwe = dmwe; r.dma = dma;
    r.dmwd = dmwd; r.e_ifr = e_ifr; r.e_dmr = e_dmr; r.e_en = e_en; r.e_we = e_we;
    r.e_busy = e_busy; r.e_addr = e_addr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: push on handshake, pop and compare on response pulse
  task automatic mon();
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      chk("rsp_timely", 32'(cyc), 32'(sbq[0].due));
      void'(sbq.pop_front());
    end
    if (if_rsp_valid || dm_rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_owner", {30'd0, if_rsp_valid, dm_rsp_valid}, e.is_if ? 32'd2 : 32'd1);
        chk("rsp_data", e.is_if ? if_rsp_data : dm_rsp_data, e.data);
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (if_req_valid && if_req_ready) sbq.push_back('{1'b1, ref_mem[if_addr], cyc + 3});
    if (dm_req_valid && dm_req_ready) begin
      if (dm_req_we) begin
        ref_mem[dm_addr] = dm_wdata;
        sbq.push_back('{1'b0, 32'd0, cyc + 3});
      end else begin
        sbq.push_back('{1'b0, ref_mem[dm_addr], cyc + 3});
      end
    end
    cyc++;
  endtask

  task automatic drive(input vec_t t);
    halted = t.hlt; if_req_valid = t.ifv; if_addr = t.ifa;
    dm_req_valid = t.dmv; dm_req_we = t.dmwe; dm_addr = t.dma; dm_wdata = t.dmwd;
  endtask

  initial begin
    vec_t  t;
    int    gq[$];
    int    exp_g[5] = '{1, 1, 1, 0, 1};
    int    k;
    bit    got;
    n_tests = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

    // fetch only
    tbl.push_back(v(0,1,10'd0, 0,0,10'd0,32'd0, 1,0,0,0,0,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,1,0,1,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,1,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,0,10'd0));
    // simultaneous: dm first, IF granted in the dm RESP cycle
    tbl.push_back(v(0,1,10'd1, 1,0,10'd8,32'd0, 0,1,0,0,0,10'd0));
    tbl.push_back(v(0,1,10'd1, 0,0,10'd0,32'd0, 0,0,1,0,1,10'd8));
    tbl.push_back(v(0,1,10'd1, 0,0,10'd0,32'd0, 0,0,0,0,1,10'd0));
    tbl.push_back(v(0,1,10'd1, 0,0,10'd0,32'd0, 1,0,0,0,0,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,1,0,1,10'd1));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,1,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,0,10'd0));
    // store then load of the same address, load accepted in the store RESP cycle
    tbl.push_back(v(0,0,10'd0, 1,1,10'd5,32'h1e, 0,1,0,0,0,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,1,1,1,10'd5));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,1,10'd0));
    tbl.push_back(v(0,0,10'd0, 1,0,10'd5,32'd0, 0,1,0,0,0,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,1,0,1,10'd5));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,1,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,0,10'd0));
    // halted: fetch blocked for 10 cycles, dm still served
    for (int i = 0; i < 10; i++) tbl.push_back(v(1,1,10'd2, 0,0,10'd0,32'd0, 0,0,0,0,0,10'd0));
    tbl.push_back(v(1,1,10'd2, 1,0,10'd3,32'd0, 0,1,0,0,0,10'd0));
    tbl.push_back(v(1,1,10'd2, 0,0,10'd0,32'd0, 0,0,1,0,1,10'd3));
    tbl.push_back(v(1,1,10'd2, 0,0,10'd0,32'd0, 0,0,0,0,1,10'd0));
    tbl.push_back(v(1,1,10'd2, 0,0,10'd0,32'd0, 0,0,0,0,0,10'd0));
    // release halt, then re-halt while the accepted fetch is in flight
    tbl.push_back(v(0,1,10'd2, 0,0,10'd0,32'd0, 1,0,0,0,0,10'd0));
    tbl.push_back(v(1,0,10'd0, 0,0,10'd0,32'd0, 0,0,1,0,1,10'd2));
    tbl.push_back(v(1,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,1,10'd0));
    tbl.push_back(v(1,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,0,10'd0));
    tbl.push_back(v(0,0,10'd0, 0,0,10'd0,32'd0, 0,0,0,0,0,10'd0));

    // reset state, with both valids high
    rst_n = 1'b0; rst4_n = 1'b0; if4_v = 1'b0; if4_addr = 10'd0;
    drive(v(0,1,10'd4, 1,1,10'd6,32'h55, 0,0,0,0,0,10'd0));
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_flags", {25'd0, if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid, mem_en, mem_we, busy}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_data", if_rsp_data | dm_rsp_data, 32'd0);
    @(posedge clk1); #1;
    rst_n = 1'b1; rst4_n = 1'b1;

    foreach (tbl[i]) begin
      t = tbl[i];
      drive(t);
      @(negedge clk1);
      mon();
      chk($sformatf("r%0d_if_ready", i), {31'd0, if_req_ready}, {31'd0, t.e_ifr});
      chk($sformatf("r%0d_dm_ready", i), {31'd0, dm_req_ready}, {31'd0, t.e_dmr});
      chk($sformatf("r%0d_mem_en", i), {31'd0, mem_en}, {31'd0, t.e_en});
      chk($sformatf("r%0d_mem_we", i), {31'd0, mem_we}, {31'd0, t.e_we});
      chk($sformatf("r%0d_busy", i), {31'd0, busy}, {31'd0, t.e_busy});
      if (t.e_en) chk($sformatf("r%0d_mem_addr", i), {22'd0, mem_addr}, {22'd0, t.e_addr});
      @(posedge clk1); #1;
    end

    // starvation: dm continuously valid alongside a pending fetch
    drive(v(0,1,10'h3ff, 1,0,10'd10,32'd0, 0,0,0,0,0,10'd0));
    k = 0;
    while (k < 40 && gq.size() < 5) begin
      @(negedge clk1);
      mon();
      got = dm_req_valid && dm_req_ready;
      if (got) gq.push_back(1);
      if (if_req_valid && if_req_ready) gq.push_back(0);
      @(posedge clk1); #1;
      if (got) dm_addr = dm_addr + 10'd1;
      k++;
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    chk("starve_grants", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) chk($sformatf("starve_grant%0d", i), 32'(gq[i]), 32'(exp_g[i]));
    repeat (8) begin
      @(negedge clk1);
      mon();
      @(posedge clk1); #1;
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("if_data_hold", if_rsp_data, init_val(10'h3ff));

    // reset in the middle of a MEM_LAT = 4 fetch
    if4_v = 1'b1; if4_addr = 10'd7;
    @(negedge clk1);
    chk("r4_accept", {31'd0, if4_rdy}, 32'd1);
    @(posedge clk1); #1;
    if4_v = 1'b0;
    repeat (2) @(posedge clk1);
    #3;
    rst4_n = 1'b0;
    #1;
    chk("r4_rst_flags", {25'd0, if4_rdy, d4_rdy, if4_rsp_v, d4_rsp_v, m4_en, m4_we, busy4}, 32'd0);
    chk("r4_rst_data", {22'd0, m4_addr} | m4_wd | if4_rsp_d | d4_rsp_d, 32'd0);
    repeat (2) @(posedge clk1);
    #1;
    rst4_n = 1'b1;
    k = 0;
    repeat (10) begin
      @(negedge clk1);
      if (if4_rsp_v || d4_rsp_v) k++;
    end
    chk("r4_no_stale_rsp", 32'(k), 32'd0);
    @(posedge clk1); #1;
    if4_v = 1'b1; if4_addr = 10'd9;
    @(negedge clk1);
    chk("r4_accept2", {31'd0, if4_rdy}, 32'd1);
    @(posedge clk1); #1;
    if4_v = 1'b0;
    k = 1;
    @(negedge clk1);
    while (!if4_rsp_v && k < 20) begin
      @(negedge clk1);
      k++;
    end
    chk("r4_latency", 32'(k), 32'd6);
    chk("r4_data", if4_rsp_d, 32'hA5A5_0009);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
